if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_if.sv | 24 ++
 rtl/if_fetch_unit.sv | 99 +++++++++
 tb/tb_if_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: program-load and control inputs, registered fetch outputs.
interface if_fetch_unit_if;
  logic       Load_En;
  logic [4:0] Load_Addr;
  logic [7:0] Load_Data;
  logic       Start;
  logic       Stall;
  logic [7:0] Instruction_Code;
  logic       RegWrite;
  logic       SMCtrl;
  logic       Valid;
  logic [4:0] PC;
  logic       Halted;

  modport master (
    output Load_En, Load_Addr, Load_Data, Start, Stall,
    input  Instruction_Code, RegWrite, SMCtrl, Valid, PC, Halted
  );

  modport slave (
    input  Load_En, Load_Addr, Load_Data, Start, Stall,
    output Instruction_Code, RegWrite, SMCtrl, Valid, PC, Halted
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: 32x8 program memory, IDLE/RUN/HALT sequencer, opcode pre-decode.
// Optional macro IF_FETCH_JUMP_EN turns opcode 2'b10 into an absolute jump.
module if_fetch_unit (
  input logic             Clk,
  input logic             Reset,
  if_fetch_unit_if.slave  bus_io
);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e     state_q;
  logic [4:0] pc_q;
  logic [7:0] instr_q;
  logic       reg_write_q;
  logic       sm_ctrl_q;
  logic       valid_q;
  logic       halted_q;

  logic [7:0] mem_q [32];

  logic [7:0] fetch_byte;
  logic [1:0] opcode;
  logic       is_halt;
  logic       is_jump;

  assign fetch_byte = mem_q[pc_q];
  assign opcode     = fetch_byte[7:6];
  assign is_halt    = (fetch_byte == 8'hFF);

`ifdef IF_FETCH_JUMP_EN
  assign is_jump = (opcode == 2'b10);
`else
  assign is_jump = 1'b0;
`endif

  // Memory is deliberately not reset so a program survives a mid-run reset.
  always_ff @(posedge Clk) begin
    if (bus_io.Load_En && (state_q != StRun)) begin
      mem_q[bus_io.Load_Addr] <= bus_io.Load_Data;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      pc_q        <= 5'd0;
      instr_q     <= 8'h00;
      reg_write_q <= 1'b0;
      sm_ctrl_q   <= 1'b0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHalt: begin
          instr_q     <= 8'h00;
          reg_write_q <= 1'b0;
          sm_ctrl_q   <= 1'b0;
          valid_q     <= 1'b0;
          if (bus_io.Start) begin
            state_q  <= StRun;
            pc_q     <= 5'd0;
            halted_q <= 1'b0;
          end
        end
        StRun: begin
          if (!bus_io.Stall) begin
            if (is_halt || is_jump) begin
              instr_q     <= 8'h00;
              reg_write_q <= 1'b0;
              sm_ctrl_q   <= 1'b0;
              valid_q     <= 1'b0;
              if (is_halt) begin
                state_q  <= StHalt;
                halted_q <= 1'b1;
              end else begin
                pc_q <= fetch_byte[4:0];
              end
            end else begin
              instr_q     <= fetch_byte;
              valid_q     <= 1'b1;
              reg_write_q <= (opcode == 2'b00) || (opcode == 2'b11);
              sm_ctrl_q   <= (opcode == 2'b11);
              pc_q        <= pc_q + 5'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus_io.Instruction_Code = instr_q;
  assign bus_io.RegWrite         = reg_write_q;
  assign bus_io.SMCtrl           = sm_ctrl_q;
  assign bus_io.Valid            = valid_q;
  assign bus_io.PC               = pc_q;
  assign bus_io.Halted           = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

  logic Clk = 1'b0;
  logic Reset;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0 idle, 1 running, 2 halted.
  logic [7:0] m_mem [32];
  int         m_pc;
  int         m_mode;
  logic [7:0] m_ic;
  logic       m_rw, m_sm, m_v, m_h;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_ic = 8'h00; m_rw = 1'b0; m_sm = 1'b0; m_v = 1'b0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_h = 1'b0;
    model_bubble();
  endtask

  task automatic model_step();
    logic [7:0] b;
    int op;
    if (m_mode != 1) begin
      if (bus.Load_En) m_mem[bus.Load_Addr] = bus.Load_Data;
      model_bubble();
      if (bus.Start) begin
        m_mode = 1; m_pc = 0; m_h = 1'b0;
      end
    end else if (!bus.Stall) begin
      b  = m_mem[m_pc];
      op = int'(b) / 64;
      if (b == 8'hFF) begin
        model_bubble();
        m_mode = 2; m_h = 1'b1;
      end
`ifdef IF_FETCH_JUMP_EN
      else if (op == 2) begin
        model_bubble();
        m_pc = int'(b) % 32;
      end
`endif
      else begin
        m_ic = b; m_v = 1'b1;
        m_rw = (op == 0) || (op == 3);
        m_sm = (op == 3);
        m_pc = (m_pc + 1) % 32;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [7:0] pc8;
    pc8 = m_pc[7:0];
    chk({tag, ".ic"}, bus.Instruction_Code, m_ic);
    chk({tag, ".rw"}, {7'd0, bus.RegWrite}, {7'd0, m_rw});
    chk({tag, ".sm"}, {7'd0, bus.SMCtrl}, {7'd0, m_sm});
    chk({tag, ".v"},  {7'd0, bus.Valid}, {7'd0, m_v});
    chk({tag, ".pc"}, {3'd0, bus.PC}, pc8);
    chk({tag, ".h"},  {7'd0, bus.Halted}, {7'd0, m_h});
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  task automatic load(input int a, input logic [7:0] d);
    bus.Load_En   = 1'b1;
    bus.Load_Addr = a[4:0];
    bus.Load_Data = d;
    cycle("load");
    bus.Load_En = 1'b0;
  endtask

  task automatic start_run();
    bus.Start = 1'b1;
    cycle("start");
    bus.Start = 1'b0;
  endtask

  // Called just after a sampling point; pulses reset between clock edges.
  task automatic async_reset(input string tag);
    bus.Start = 1'b0; bus.Stall = 1'b0; bus.Load_En = 1'b0;
    #3;
    Reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    bus.Load_En = 1'b0; bus.Load_Addr = 5'd0; bus.Load_Data = 8'h00;
    bus.Start = 1'b0; bus.Stall = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    model_reset();
    #2;
    compare_all("por");
    #10;
    Reset = 1'b1;
    cycle("idle_hold");

    // Two instructions then HALT.
    load(0, 8'h09); load(1, 8'hC1); load(2, 8'hFF);
    start_run();
    cycle("halt_seq1");
    chk("halt_seq1.const_ic", bus.Instruction_Code, 8'h09);
    cycle("halt_seq2");
    chk("halt_seq2.const_ic", bus.Instruction_Code, 8'hC1);
    chk("halt_seq2.const_sm", {7'd0, bus.SMCtrl}, 8'h01);
    cycle("halt_seq3");
    chk("halt_seq3.const_h",  {7'd0, bus.Halted}, 8'h01);
    chk("halt_seq3.const_pc", {3'd0, bus.PC}, 8'h02);

    // Stall holds first output; loads accepted in HALT.
    load(0, 8'h12); load(1, 8'h1A);
    start_run();
    cycle("stall_first");
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("stall_hold");
      chk("stall_hold.const_ic", bus.Instruction_Code, 8'h12);
      chk("stall_hold.const_pc", {3'd0, bus.PC}, 8'h01);
    end
    bus.Stall = 1'b0;
    cycle("stall_release");
    chk("stall_release.const_ic", bus.Instruction_Code, 8'h1A);
    cycle("stall_to_halt");

    // PC wrap from 31 to 0.
    for (int i = 0; i < 31; i++) load(i, 8'h01);
    load(31, 8'h05);
    start_run();
    for (int i = 0; i < 31; i++) cycle("wrap_walk");
    cycle("wrap");
    chk("wrap.const_ic", bus.Instruction_Code, 8'h05);
    chk("wrap.const_pc", {3'd0, bus.PC}, 8'h00);

    // Reset mid-run at PC=7, memory retained.
    for (int i = 0; i < 7; i++) cycle("to_pc7");
    chk("to_pc7.const_pc", {3'd0, bus.PC}, 8'h07);
    async_reset("mid_run_reset");
    cycle("post_reset_idle");
    start_run();
    cycle("replay0");
    chk("replay0.const_ic", bus.Instruction_Code, 8'h01);

    // Load during RUN is ignored.
    bus.Load_En = 1'b1; bus.Load_Addr = 5'd3; bus.Load_Data = 8'hAA;
    cycle("run_load1");
    cycle("run_load2");
    bus.Load_En = 1'b0;
    cycle("run_load_fetch3");
    chk("run_load_fetch3.const_ic", bus.Instruction_Code, 8'h01);

    // Opcode 10 behaviour.
    async_reset("jmp_reset");
    load(0, 8'h84); load(4, 8'h47);
    start_run();
    cycle("op10_first");
`ifdef IF_FETCH_JUMP_EN
    chk("op10_first.const_v",  {7'd0, bus.Valid}, 8'h00);
    chk("op10_first.const_pc", {3'd0, bus.PC}, 8'h04);
    cycle("op10_target");
    chk("op10_target.const_ic", bus.Instruction_Code, 8'h47);
`else
    chk("op10_first.const_ic", bus.Instruction_Code, 8'h84);
    chk("op10_first.const_pc", {3'd0, bus.PC}, 8'h01);
    chk("op10_first.const_rw", {7'd0, bus.RegWrite}, 8'h00);
`endif

    // Randomized traffic.
    async_reset("rand_reset");
    for (int i = 0; i < 32; i++) load(i, 8'($urandom));
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 99) async_reset("rand_periodic_reset");
      bus.Load_En   = ($urandom_range(0, 2) == 0);
      bus.Load_Addr = 5'($urandom);
      bus.Load_Data = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      bus.Start     = ($urandom_range(0, 7) == 0);
      bus.Stall     = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
